// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, combinational ROM access, and a
// 2-entry skid FIFO toward decode. Optional FETCH_HALT_ON_ZERO_EN halts on zero words.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_out,
    input  logic [31:0] instr_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        misalign_err,
    output logic        halted
);

    // Handshake: an entry transfers to decode on a rising edge where
    // id_valid & id_ready are both high; id_* stay stable until that edge.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t        state_q, state_d;
    logic [31:0] pc_reg, pc_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] head_instr_q, head_instr_d;
    logic [31:0] head_plus4_q, head_plus4_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic [31:0] tail_instr_q, tail_instr_d;
    logic        misalign_q, misalign_d;
    logic        halted_q, halted_d;
    logic        pop;
    logic        fetch_slot;
    logic        zero_word;
    logic        push;

    assign pop        = (state_q != EMPTY) & id_ready;
    assign fetch_slot = ((state_q != FULL) | pop) & ~redirect_valid & ~halted_q;
`ifdef FETCH_HALT_ON_ZERO_EN
    assign zero_word  = (instr_in == 32'h0000_0000);
`else
    assign zero_word  = 1'b0;
`endif
    assign push       = fetch_slot & ~zero_word;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_reg;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        head_plus4_d = head_plus4_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;
        misalign_d   = misalign_q;
        halted_d     = halted_q;

        if (redirect_valid) begin
            // Flush discards any same-cycle pop or push; head data is left as-is.
            state_d    = EMPTY;
            pc_d       = {redirect_pc[31:2], 2'b00};
            misalign_d = misalign_q | (redirect_pc[1:0] != 2'b00);
            halted_d   = 1'b0;
        end else begin
            if (fetch_slot & zero_word) begin
                halted_d = 1'b1;
            end
            if (push) begin
                pc_d = pc_reg + PC_STEP;
            end
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_pc_d    = pc_reg;
                        head_instr_d = instr_in;
                        head_plus4_d = pc_reg + 32'd4;
                        state_d      = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_pc_d    = pc_reg;
                        head_instr_d = instr_in;
                        head_plus4_d = pc_reg + 32'd4;
                    end else if (push) begin
                        tail_pc_d    = pc_reg;
                        tail_instr_d = instr_in;
                        state_d      = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_pc_d    = tail_pc_q;
                        head_instr_d = tail_instr_q;
                        head_plus4_d = tail_pc_q + 32'd4;
                        if (push) begin
                            tail_pc_d    = pc_reg;
                            tail_instr_d = instr_in;
                        end else begin
                            state_d = ONE;
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            pc_reg       <= RESET_PC;
            head_pc_q    <= 32'd0;
            head_instr_q <= 32'd0;
            head_plus4_q <= 32'd0;
            tail_pc_q    <= 32'd0;
            tail_instr_q <= 32'd0;
            misalign_q   <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_reg       <= pc_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            head_plus4_q <= head_plus4_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
            misalign_q   <= misalign_d;
            halted_q     <= halted_d;
        end
    end

    assign pc_out       = pc_reg;
    assign id_valid     = (state_q != EMPTY);
    assign id_pc        = head_pc_q;
    assign id_instr     = head_instr_q;
    assign id_pc_plus4  = head_plus4_q;
    assign misalign_err = misalign_q;
`ifdef FETCH_HALT_ON_ZERO_EN
    assign halted       = halted_q;
`else
    assign halted       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed bring-up scenarios plus
// randomized back-pressure/redirect traffic against a queue-based reference model.
module tb_fetch_stage;

`ifdef FETCH_HALT_ON_ZERO_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        misalign_err;
    logic        halted;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .instr_in(instr_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc),
        .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
        .misalign_err(misalign_err), .halted(halted)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bring-up program; unmapped addresses read as zero
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'd0:   rom = 32'h00a00513;
            32'd4:   rom = 32'h00100593;
            32'd8:   rom = 32'h00b50633;
            32'd12:  rom = 32'h40b606b3;
            32'd16:  rom = 32'h00c02223;
            32'd20:  rom = 32'h7e350113;
            32'd24:  rom = 32'h0ff00713;
            32'd28:  rom = 32'h00e787b3;
            32'd32:  rom = 32'hfe079ee3;
            32'd36:  rom = 32'h00008067;
            32'd40:  rom = 32'h7ea12fa3;
            default: rom = 32'h00000000;
        endcase
    endfunction

    assign instr_in = rom(pc_out);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: decode-side queue of {pc, instr}
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    logic        m_mis;
    logic        m_halt;
    logic [31:0] m_last_pc;
    logic [31:0] m_last_instr;

    task automatic model_edge();
        bit          pop_now;
        bit          slot;
        logic [31:0] w;
        if (rst) begin
            exp_q.delete();
            m_pc = 32'd0; m_mis = 1'b0; m_halt = 1'b0;
            m_last_pc = 32'd0; m_last_instr = 32'd0;
        end else if (redirect_valid) begin
            exp_q.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            m_mis = m_mis | (redirect_pc[1:0] != 2'b00);
            m_halt = 1'b0;
        end else begin
            pop_now = (exp_q.size() > 0) && id_ready;
            slot = ((exp_q.size() < 2) || pop_now) && !m_halt;
            if (pop_now) void'(exp_q.pop_front());
            if (slot) begin
                w = rom(m_pc);
                if (HALT_EN && w == 32'd0) begin
                    m_halt = 1'b1;
                end else begin
                    exp_q.push_back({m_pc, w});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        if (exp_q.size() > 0) begin
            m_last_pc = exp_q[0][63:32];
            m_last_instr = exp_q[0][31:0];
        end
    endtask

    // driver: one clock edge, model update, then compare away from the edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("id_valid", {31'd0, id_valid}, {31'd0, exp_q.size() > 0});
        check("pc_out", pc_out, m_pc);
        check("id_pc", id_pc, m_last_pc);
        check("id_instr", id_instr, m_last_instr);
        check("id_pc_plus4", id_pc_plus4, (exp_q.size() > 0 || m_last_pc != 0 || m_last_instr != 0) ? m_last_pc + 32'd4 : 32'd0);
        check("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
        check("halted", {31'd0, halted}, {31'd0, m_halt});
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; id_ready = 1'b0;

        // bring-up with decode always ready
        id_ready = 1'b1;
        do_reset();
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_plus4", id_pc_plus4, 32'd0);
        for (int i = 0; i < 11; i++) begin
            tick();
            check("run_valid", {31'd0, id_valid}, 32'd1);
            check("run_pc", id_pc, 32'(i * 4));
            check("run_plus4", id_pc_plus4, 32'(i * 4 + 4));
            if (i == 5) check("run_instr20", id_instr, 32'h7e350113);
        end
        tick();
`ifdef FETCH_HALT_ON_ZERO_EN
        check("halt_valid", {31'd0, id_valid}, 32'd0);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_pc_out", pc_out, 32'd44);
        tick();
        check("halt_hold", pc_out, 32'd44);
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        tick();
        redirect_valid = 1'b0;
        check("halt_clear", {31'd0, halted}, 32'd0);
        tick();
        check("refetch_instr", id_instr, 32'h00a00513);
`else
        check("zero_pc", id_pc, 32'd44);
        check("zero_instr", id_instr, 32'd0);
        check("zero_halted", {31'd0, halted}, 32'd0);
`endif

        // stall until full, then release
        id_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        check("stall_pc_out", pc_out, 32'd8);
        check("stall_pc", id_pc, 32'd0);
        check("stall_instr", id_instr, 32'h00a00513);
        id_ready = 1'b1;
        tick();
        check("drain_pc4", id_pc, 32'd4);
        tick();
        check("drain_pc8", id_pc, 32'd8);

        // redirect while full and stalled
        id_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        redirect_valid = 1'b1; redirect_pc = 32'd20;
        tick();
        redirect_valid = 1'b0;
        check("redir_valid", {31'd0, id_valid}, 32'd0);
        check("redir_pc_out", pc_out, 32'd20);
        tick();
        check("redir_pc", id_pc, 32'd20);
        check("redir_instr", id_instr, 32'h7e350113);

        // misaligned target, sticky error
        redirect_valid = 1'b1; redirect_pc = 32'h13;
        tick();
        check("mis_pc_out", pc_out, 32'h10);
        check("mis_flag", {31'd0, misalign_err}, 32'd1);
        redirect_pc = 32'd8;
        tick();
        redirect_valid = 1'b0;
        check("mis_sticky", {31'd0, misalign_err}, 32'd1);
        do_reset();
        check("mis_clear", {31'd0, misalign_err}, 32'd0);

        // PC wrap at the top of the address space
        id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
`ifndef FETCH_HALT_ON_ZERO_EN
        check("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", id_pc_plus4, 32'd0);
        tick();
        check("wrap_next", id_pc, 32'd0);
`else
        check("wrap_halt", {31'd0, halted}, 32'd1);
`endif

        // randomized traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0: redirect_pc = 32'($urandom_range(0, 47));
                1: redirect_pc = 32'hFFFF_FFF8;
                default: redirect_pc = 32'($urandom_range(0, 11) * 4);
            endcase
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0; redirect_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end. Owns the program counter, drives the address into the combinational instruction ROM, and captures each returned word with its PC.
- Captured words go into a 2-entry skid FIFO that feeds decode through a valid/ready handshake.
- Handles decode back-pressure, and branch/jump redirects from execute that flush in-flight fetches.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- PC_STEP, 32'd4, PC increment per fetched word.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- pc_out  out  32  fetch address to the instruction ROM; combinational copy of pc_reg.
- instr_in  in  32  ROM word for pc_out, valid in the same cycle.
- redirect_valid  in  1  execute requests a control-flow change this cycle.
- redirect_pc  in  32  new fetch target.
- id_ready  in  1  decode accepts the head entry this cycle.
- id_valid  out  1  head entry valid.
- id_pc  out  32  PC of head entry.
- id_instr  out  32  instruction of head entry.
- id_pc_plus4  out  32  id_pc + 4, wraps mod 2^32.
- misalign_err  out  1  sticky; set when a redirect target has nonzero bits [1:0].
- halted  out  1  fetch halted (see Optional Feature); constant 0 when the feature is compiled out.

Behaviour:
- Reset (rst=1 at edge):
  - pc_reg <= RESET_PC.
  - FIFO emptied; count=0; id_valid=0.
  - id_pc, id_instr, id_pc_plus4 = 0.
  - misalign_err=0, halted=0.
  - Reset overrides redirect and handshake in the same cycle.
- Outputs: the id_* outputs are driven from the FIFO head registers. There is no combinational path from instr_in to the id_* outputs.
- pop = id_valid & id_ready.
- push condition: (count<2 or pop) & ~redirect_valid & ~halted.
- On push:
  - {pc_reg, instr_in} written to the FIFO tail.
  - pc_reg <= pc_reg + PC_STEP, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- Same-cycle push and pop: the count is unchanged, and ordering is strictly preserved.
- Latency: a word fetched at edge N is presented on id_* after edge N, i.e. id_valid rises one cycle after the fetch.
- Full (count==2, no pop): pc_reg holds, and pc_out repeats the same address. The ROM is combinational, so re-reading is harmless.
- Empty (count==0): id_valid=0. The id_* data outputs hold their last values; decode must qualify them with id_valid.
- Redirect (redirect_valid=1 at edge, rst=0):
  - Highest priority after reset.
  - FIFO flushed (count <= 0), including any same-cycle pop/push.
  - pc_reg <= {redirect_pc[31:2], 2'b00}.
  - misalign_err <= misalign_err | (redirect_pc[1:0] != 0).
  - halted <= 0.
  - id_valid=0 for the following cycle. The first word from the target appears on id_* two edges after the redirect.
- Back-to-back redirects: each one flushes again; the last one wins.
- Redirect while full and stalled: the flush occurs regardless of id_ready.
- States (implicit in count): EMPTY(0), ONE(1), FULL(2); HALT is additional when enabled.
  - EMPTY -> ONE on push.
  - ONE -> FULL on push without pop.
  - FULL -> ONE on pop without push.
  - ONE -> EMPTY on pop without push.
  - Any state -> EMPTY on redirect.

Optional Feature:
- Macro: FETCH_HALT_ON_ZERO_EN.
- Defined:
  - An instr_in of 32'h00000000 (the ROM default for unmapped addresses) is never pushed.
  - At the edge where it would have been pushed, halted <= 1 and pc_reg holds at that address.
  - Words already in the FIFO still drain normally.
  - halted is cleared only by reset or redirect.
- Undefined:
  - Zero words are pushed and advanced like any other word.
  - halted is tied to 0.

Test Plan:
1. Reset, then id_ready=1 continuously, using the standard bring-up program (0x00a00513@0 ... 0x7ea12fa3@40) → id_valid rises one cycle after reset release; id_pc=0,4,8,...,40 on consecutive cycles with matching id_instr (e.g. id_pc=20 → 0x7e350113); id_pc_plus4 = id_pc+4.
2. Reset, then hold id_ready=0 for 5 cycles → count saturates at 2; pc_out stays at 8; id_pc=0 and id_instr=0x00a00513 stable. Then release → 0, 4, 8 are delivered in order with no duplicates and no gaps.
3. Stalled with FIFO full; assert redirect_valid with redirect_pc=20 for 1 cycle → next cycle id_valid=0 and pc_out=20; the cycle after, id_pc=20 and id_instr=0x7e350113.
4. Redirect with redirect_pc=0x13 → pc_out=0x10 and misalign_err=1. misalign_err stays 1 through a later aligned redirect, and clears only on rst.
5. Redirect to 0xFFFFFFFC with id_ready=1 → id_pc=0xFFFFFFFC with id_pc_plus4=0, then id_pc=0x00000000.
6. With FETCH_HALT_ON_ZERO_EN defined, run from reset with id_ready=1 → exactly 11 words (PC 0..40) are delivered; halted=1 and pc_out=44 stay held; a redirect to 0 clears halted and refetches 0x00a00513. Compiled without the macro → id_pc=44 is delivered with id_instr=0 and halted stays 0.
